srmem_wr_arbiter: RTL and testbench

- Burst-granular write-side arbiter that shares the single write port of a double-buffered shift-register memory between NUM_REQ producers.
- Grants one producer for a whole burst (last beat flagged) in round-robin order. Forwards beats while the memory is not full.
- Truncates bursts that exceed the memory depth so that a buffer always closes cleanly and the ping-pong flip always occurs.
- Sits between the syndrome/data producers and the memory's valid_din/din/is_lastdin/wrfull port.

---
 rtl/srmem_wr_arbiter_pkg.sv | 13 +
 rtl/srmem_wr_arbiter_rr_pick.sv | 30 +++
 rtl/srmem_wr_arbiter.sv | 167 ++++++++++++++++
 tb/tb_srmem_wr_arbiter.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/srmem_wr_arbiter_pkg.sv
// Shared constants for the srmem write-side arbiter.
// Defining SRMEM_ARB_STATS_EN adds per-producer burst statistics.
package srmem_wr_arbiter_pkg;

  localparam logic [1:0] ARB_IDLE   = 2'd0;
  localparam logic [1:0] ARB_STREAM = 2'd1;
  localparam logic [1:0] ARB_DRAIN  = 2'd2;

`ifdef SRMEM_ARB_STATS_EN
  localparam int STATS_W = 16;
`endif

endpackage

// File: rtl/srmem_wr_arbiter_rr_pick.sv
// Combinational round-robin finder: first set bit of req_i at or after ptr_i,
// wrapping cyclically.
module srmem_wr_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_BW   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_BW-1:0]   ptr_i,
  output logic               found_o,
  output logic [ID_BW-1:0]   idx_o
);

  logic [2*NUM_REQ-1:0] req2;
  logic [NUM_REQ-1:0]   rot;
  logic [ID_BW:0]       sum;

  // Rotate so that ptr_i sits at bit 0, then take the lowest set bit.
  always_comb begin
    req2    = {req_i, req_i} >> ptr_i;
    rot     = req2[NUM_REQ-1:0];
    found_o = |rot;
    sum     = '0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) sum = (ID_BW+1)'(j) + {1'b0, ptr_i};
    end
    if (sum >= (ID_BW+1)'(NUM_REQ)) sum = sum - (ID_BW+1)'(NUM_REQ);
    idx_o = sum[ID_BW-1:0];
  end

endmodule

// File: rtl/srmem_wr_arbiter.sv
// Burst-granular round-robin write arbiter for a double-buffered srmem.
// Optional feature macro: SRMEM_ARB_STATS_EN (adds burst_count output).
module srmem_wr_arbiter
  import srmem_wr_arbiter_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int DATA_BW   = 8,
  parameter  int LEN_SRMEM = 4,
  localparam int ID_BW     = $clog2(NUM_REQ)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_BW-1:0] req_din,
  input  logic [NUM_REQ-1:0]         req_last,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       mem_valid_din,
  output logic [DATA_BW-1:0]         mem_din,
  output logic                       mem_is_lastdin,
  input  logic                       mem_wrfull,
  output logic [ID_BW-1:0]           grant_id,
  output logic                       busy,
  output logic                       trunc_err
`ifdef SRMEM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*STATS_W-1:0] burst_count
`endif
);

  localparam int CNT_W = $clog2(LEN_SRMEM);

  logic [1:0]         state_q, state_d;
  logic [ID_BW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_BW-1:0]   grant_q, grant_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               trunc_q, trunc_d;

  logic               pick_found;
  logic [ID_BW-1:0]   pick_idx;
  logic [DATA_BW-1:0] din_arr [NUM_REQ];
  logic               g_valid, g_last, cnt_max, xfer, done;
  logic [ID_BW-1:0]   g_next;

  srmem_wr_arbiter_rr_pick #(
    .NUM_REQ(NUM_REQ),
    .ID_BW  (ID_BW)
  ) u_rr_pick (
    .req_i  (req_valid),
    .ptr_i  (rr_ptr_q),
    .found_o(pick_found),
    .idx_o  (pick_idx)
  );

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_din
    assign din_arr[gi] = req_din[gi*DATA_BW +: DATA_BW];
  end

  assign g_valid = req_valid[grant_q];
  assign g_last  = req_last[grant_q];
  assign cnt_max = (cnt_q == CNT_W'(LEN_SRMEM - 1));
  assign g_next  = (grant_q == ID_BW'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
  assign done    = ((state_q == ARB_STREAM) & xfer & g_last) |
                   ((state_q == ARB_DRAIN) & g_valid & g_last);

  // Zero-latency path from the owner to the memory; outputs are zeroed when idle.
  always_comb begin
    req_ready      = '0;
    mem_valid_din  = 1'b0;
    mem_din        = '0;
    mem_is_lastdin = 1'b0;
    xfer           = 1'b0;
    case (state_q)
      ARB_STREAM: begin
        req_ready[grant_q] = !mem_wrfull;
        xfer               = g_valid & !mem_wrfull;
        if (xfer) begin
          mem_valid_din  = 1'b1;
          mem_din        = din_arr[grant_q];
          mem_is_lastdin = g_last | cnt_max;
        end
      end
      ARB_DRAIN: req_ready[grant_q] = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    cnt_d    = cnt_q;
    trunc_d  = trunc_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found && !mem_wrfull) begin
          grant_d = pick_idx;
          cnt_d   = '0;
          state_d = ARB_STREAM;
        end
      end
      ARB_STREAM: begin
        if (xfer) begin
          if (g_last) begin
            cnt_d    = '0;
            rr_ptr_d = g_next;
            state_d  = ARB_IDLE;
          end else if (cnt_max) begin
            // Buffer already closed by the forced last; swallow the remainder.
            trunc_d = 1'b1;
            state_d = ARB_DRAIN;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      ARB_DRAIN: begin
        if (g_valid && g_last) begin
          cnt_d    = '0;
          rr_ptr_d = g_next;
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      cnt_q    <= '0;
      trunc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      cnt_q    <= cnt_d;
      trunc_q  <= trunc_d;
    end
  end

  assign grant_id  = grant_q;
  assign busy      = (state_q != ARB_IDLE);
  assign trunc_err = trunc_q;

`ifdef SRMEM_ARB_STATS_EN
  logic [STATS_W-1:0] stat_q [NUM_REQ];

  function automatic logic [STATS_W-1:0] sat_inc(input logic [STATS_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else if (done) begin
      stat_q[grant_q] <= sat_inc(stat_q[grant_q]);
    end
  end

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stats
    assign burst_count[gi*STATS_W +: STATS_W] = stat_q[gi];
  end
`endif

endmodule

// File: tb/tb_srmem_wr_arbiter.sv
// Table-driven bench for srmem_wr_arbiter (NUM_REQ=4, DATA_BW=8, LEN_SRMEM=4).
module tb_srmem_wr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_din;
  logic [3:0]  req_last;
  logic [3:0]  req_ready;
  logic        mem_valid_din;
  logic [7:0]  mem_din;
  logic        mem_is_lastdin;
  logic        mem_wrfull;
  logic [1:0]  grant_id;
  logic        busy;
  logic        trunc_err;
`ifdef SRMEM_ARB_STATS_EN
  logic [63:0] burst_count;
`endif

  int checks = 0;
  int errors = 0;

  srmem_wr_arbiter #(.NUM_REQ(4), .DATA_BW(8), .LEN_SRMEM(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .req_valid     (req_valid),
    .req_din       (req_din),
    .req_last      (req_last),
    .req_ready     (req_ready),
    .mem_valid_din (mem_valid_din),
    .mem_din       (mem_din),
    .mem_is_lastdin(mem_is_lastdin),
    .mem_wrfull    (mem_wrfull),
    .grant_id      (grant_id),
    .busy          (busy),
    .trunc_err     (trunc_err)
`ifdef SRMEM_ARB_STATS_EN
    ,
    .burst_count   (burst_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        r;
    logic [3:0]  v;
    logic [31:0] d;
    logic [3:0]  l;
    logic        wf;
    logic [3:0]  e_rdy;
    logic        e_mv;
    logic [7:0]  e_din;
    logic        e_last;
    logic [1:0]  e_gid;
    logic        e_busy;
    logic        e_trunc;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(input logic r, input logic [3:0] v, input logic [31:0] d,
                              input logic [3:0] l, input logic wf, input logic [3:0] er,
                              input logic em, input logic [7:0] ed, input logic el,
                              input logic [1:0] eg, input logic eb, input logic et);
    vec_t x;
    x.r = r; x.v = v; x.d = d; x.l = l; x.wf = wf;
    x.e_rdy = er; x.e_mv = em; x.e_din = ed; x.e_last = el;
    x.e_gid = eg; x.e_busy = eb; x.e_trunc = et;
    return x;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] v, input logic [31:0] d,
                       input logic [3:0] l, input logic wf);
    rst = r; req_valid = v; req_din = d; req_last = l; mem_wrfull = wf;
  endtask

  initial begin
    drive(1'b1, 4'h0, 32'h0, 4'h0, 1'b0);
    repeat (2) @(posedge clk);

    // reset row
    tbl.push_back(mk(1'b1, 4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0));
    // round robin, 1-beat bursts from all producers (rows 1..16)
    for (int k = 0; k < 2; k++) begin
      tbl.push_back(mk(1'b0, 4'hF, 32'hB3B2B1B0, 4'hF, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, (k == 0) ? 2'd0 : 2'd3, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 4'hF, 32'hB3B2B1B0, 4'hF, 1'b0, 4'h1, 1'b1, 8'hB0, 1'b1, 2'd0, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 4'hF, 32'hB3B2B1B0, 4'hF, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 4'hF, 32'hB3B2B1B0, 4'hF, 1'b0, 4'h2, 1'b1, 8'hB1, 1'b1, 2'd1, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 4'hF, 32'hB3B2B1B0, 4'hF, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 4'hF, 32'hB3B2B1B0, 4'hF, 1'b0, 4'h4, 1'b1, 8'hB2, 1'b1, 2'd2, 1'b1, 1'b0));
      tbl.push_back(mk(1'b0, 4'hF, 32'hB3B2B1B0, 4'hF, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd2, 1'b0, 1'b0));
      tbl.push_back(mk(1'b0, 4'hF, 32'hB3B2B1B0, 4'hF, 1'b0, 4'h8, 1'b1, 8'hB3, 1'b1, 2'd3, 1'b1, 1'b0));
    end
    // producer 0: A1,A2,A3 (rows 17..22)
    tbl.push_back(mk(1'b0, 4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd3, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 4'h1, 32'h000000A1, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd3, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 4'h1, 32'h000000A1, 4'h0, 1'b0, 4'h1, 1'b1, 8'hA1, 1'b0, 2'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 4'h1, 32'h000000A2, 4'h0, 1'b0, 4'h1, 1'b1, 8'hA2, 1'b0, 2'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 4'h1, 32'h000000A3, 4'h1, 1'b0, 4'h1, 1'b1, 8'hA3, 1'b1, 2'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0));
    // producer 2: 6 beats, truncated after 4 (rows 23..30)
    tbl.push_back(mk(1'b0, 4'h4, 32'h00C10000, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 4'h4, 32'h00C10000, 4'h0, 1'b0, 4'h4, 1'b1, 8'hC1, 1'b0, 2'd2, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 4'h4, 32'h00C20000, 4'h0, 1'b0, 4'h4, 1'b1, 8'hC2, 1'b0, 2'd2, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 4'h4, 32'h00C30000, 4'h0, 1'b0, 4'h4, 1'b1, 8'hC3, 1'b0, 2'd2, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 4'h4, 32'h00C40000, 4'h0, 1'b0, 4'h4, 1'b1, 8'hC4, 1'b1, 2'd2, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 4'h4, 32'h00C50000, 4'h0, 1'b0, 4'h4, 1'b0, 8'h00, 1'b0, 2'd2, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 4'h4, 32'h00C60000, 4'h4, 1'b0, 4'h4, 1'b0, 8'h00, 1'b0, 2'd2, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd2, 1'b0, 1'b1));
    // producer 1 (grant wraps from ptr 3), wrfull in IDLE then 3-cycle stall (rows 31..39)
    tbl.push_back(mk(1'b0, 4'h2, 32'h0000D100, 4'h0, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 2'd2, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'h2, 32'h0000D100, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd2, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'h2, 32'h0000D100, 4'h0, 1'b0, 4'h2, 1'b1, 8'hD1, 1'b0, 2'd1, 1'b1, 1'b1));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(1'b0, 4'h2, 32'h0000D200, 4'h0, 1'b1, 4'h0, 1'b0, 8'h00, 1'b0, 2'd1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 4'h2, 32'h0000D200, 4'h0, 1'b0, 4'h2, 1'b1, 8'hD2, 1'b0, 2'd1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 4'h2, 32'h0000D300, 4'h2, 1'b0, 4'h2, 1'b1, 8'hD3, 1'b1, 2'd1, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0, 1'b1));
    // producer 3, reset at beat 2, then fresh grant from producer 0 (rows 40..46)
    tbl.push_back(mk(1'b0, 4'h8, 32'hE1000000, 4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd1, 1'b0, 1'b1));
    tbl.push_back(mk(1'b0, 4'h8, 32'hE1000000, 4'h0, 1'b0, 4'h8, 1'b1, 8'hE1, 1'b0, 2'd3, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 4'h8, 32'hE2000000, 4'h0, 1'b0, 4'h8, 1'b1, 8'hE2, 1'b0, 2'd3, 1'b1, 1'b1));
    tbl.push_back(mk(1'b1, 4'h8, 32'hE3000000, 4'h0, 1'b0, 4'h8, 1'b1, 8'hE3, 1'b0, 2'd3, 1'b1, 1'b1));
    tbl.push_back(mk(1'b0, 4'h9, 32'hE30000F0, 4'h9, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 4'h9, 32'hE30000F0, 4'h9, 1'b0, 4'h1, 1'b1, 8'hF0, 1'b1, 2'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 4'h0, 32'h0,        4'h0, 1'b0, 4'h0, 1'b0, 8'h00, 1'b0, 2'd0, 1'b0, 1'b0));

    foreach (tbl[i]) begin
      @(negedge clk);
`ifdef SRMEM_ARB_STATS_EN
      if (i == 17) chk("burst_count_rr", 64'(burst_count), {4{16'd2}});
`endif
      drive(tbl[i].r, tbl[i].v, tbl[i].d, tbl[i].l, tbl[i].wf);
      #1;
      chk($sformatf("req_ready[%0d]", i),      64'(req_ready),      64'(tbl[i].e_rdy));
      chk($sformatf("mem_valid_din[%0d]", i),  64'(mem_valid_din),  64'(tbl[i].e_mv));
      chk($sformatf("mem_din[%0d]", i),        64'(mem_din),        64'(tbl[i].e_din));
      chk($sformatf("mem_is_lastdin[%0d]", i), 64'(mem_is_lastdin), 64'(tbl[i].e_last));
      chk($sformatf("grant_id[%0d]", i),       64'(grant_id),       64'(tbl[i].e_gid));
      chk($sformatf("busy[%0d]", i),           64'(busy),           64'(tbl[i].e_busy));
      chk($sformatf("trunc_err[%0d]", i),      64'(trunc_err),      64'(tbl[i].e_trunc));
    end

    // Producer 1 goes quiet mid-burst: grant must persist with no timeout.
    @(negedge clk);
    drive(1'b0, 4'h2, 32'h00005A00, 4'h0, 1'b0);
    #1 chk("drop_idle_busy", 64'(busy), 64'd0);
    @(negedge clk);
    #1;
    chk("drop_first_mv", 64'(mem_valid_din), 64'd1);
    chk("drop_first_din", 64'(mem_din), 64'h5A);
    chk("drop_first_gid", 64'(grant_id), 64'd1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b0);
      #1;
      chk($sformatf("drop_hold_busy[%0d]", k), 64'(busy), 64'd1);
      chk($sformatf("drop_hold_gid[%0d]", k), 64'(grant_id), 64'd1);
      chk($sformatf("drop_hold_mv[%0d]", k), 64'(mem_valid_din), 64'd0);
      chk($sformatf("drop_hold_rdy[%0d]", k), 64'(req_ready), 64'h2);
    end
    @(negedge clk);
    drive(1'b0, 4'h2, 32'h00005B00, 4'h2, 1'b0);
    #1;
    chk("drop_resume_mv", 64'(mem_valid_din), 64'd1);
    chk("drop_resume_din", 64'(mem_din), 64'h5B);
    chk("drop_resume_last", 64'(mem_is_lastdin), 64'd1);
    @(negedge clk);
    drive(1'b0, 4'h0, 32'h0, 4'h0, 1'b0);
    #1 chk("drop_end_busy", 64'(busy), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
